// File: rtl/mdu_hilo.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// Define MDU_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are all zero.
module mdu_hilo #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] RS_Data,
    input  logic [DATA_W-1:0] RT_Data,
    input  logic              Read_Req,
    input  logic              Flush,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              Busy,
    output logic              Done,
    output logic              Stall
);

    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMMIT} state_t;

    state_t                  state_reg;
    logic [2*DATA_W-1:0]     acc_reg;
    logic [2*DATA_W-1:0]     mcand_reg;
    logic [DATA_W-1:0]       b_reg;
    logic [DATA_W-1:0]       hi_reg;
    logic [DATA_W-1:0]       lo_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    is_div_reg;
    logic                    dbz_reg;
    logic                    neg_q_reg;
    logic                    neg_r_reg;
    logic                    done_reg;

    logic                    op_signed;
    logic                    op_mul;
    logic                    op_div;
    logic [DATA_W-1:0]       rs_abs;
    logic [DATA_W-1:0]       rt_abs;
    logic [2*DATA_W-1:0]     mul_next;
    logic [DATA_W:0]         rem_shift;
    logic [DATA_W-1:0]       rem_diff;
    logic                    rem_ge;
    logic [2*DATA_W-1:0]     div_next;
    logic [2*DATA_W-1:0]     prod;
    logic [DATA_W-1:0]       quo;
    logic [DATA_W-1:0]       rem;
    logic                    last_iter;

    always_comb begin
        op_signed = ~Op[0];
        op_mul    = (Op[2:1] == 2'b00);
        op_div    = (Op[2:1] == 2'b01);
        rs_abs    = (op_signed && RS_Data[DATA_W-1]) ? -RS_Data : RS_Data;
        rt_abs    = (op_signed && RT_Data[DATA_W-1]) ? -RT_Data : RT_Data;

        mul_next  = b_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

        // Restoring step on {remainder, quotient}: shift in the next dividend bit, subtract if it fits.
        rem_shift = acc_reg[2*DATA_W-1:DATA_W-1];
        rem_ge    = (rem_shift >= {1'b0, b_reg});
        rem_diff  = rem_shift[DATA_W-1:0] - b_reg;
        div_next  = rem_ge ? {rem_diff, acc_reg[DATA_W-2:0], 1'b1}
                           : {rem_shift[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b0};

        prod      = neg_q_reg ? -acc_reg : acc_reg;
        quo       = neg_q_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
        rem       = neg_r_reg ? -acc_reg[2*DATA_W-1:DATA_W] : acc_reg[2*DATA_W-1:DATA_W];

`ifdef MDU_EARLY_TERM_EN
        last_iter = (cnt_reg == CNT_W'(ITER - 1)) ||
                    (!is_div_reg && (b_reg[DATA_W-1:1] == '0));
`else
        last_iter = (cnt_reg == CNT_W'(ITER - 1));
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            b_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            dbz_reg    <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        if (Op == 3'b100) begin
                            hi_reg <= RS_Data;
                        end else if (Op == 3'b101) begin
                            lo_reg <= RS_Data;
                        end else if (op_mul || op_div) begin
                            is_div_reg <= op_div;
                            neg_q_reg  <= op_signed & (RS_Data[DATA_W-1] ^ RT_Data[DATA_W-1]);
                            neg_r_reg  <= op_signed & RS_Data[DATA_W-1];
                            cnt_reg    <= '0;
                            b_reg      <= rt_abs;
                            mcand_reg  <= {{DATA_W{1'b0}}, rs_abs};
                            if (op_div && (RT_Data == '0)) begin
                                // Divide by zero: park the raw dividend where HI is taken from at commit.
                                dbz_reg   <= 1'b1;
                                acc_reg   <= {RS_Data, {DATA_W{1'b0}}};
                                state_reg <= S_COMMIT;
                            end else begin
                                dbz_reg   <= 1'b0;
                                acc_reg   <= op_div ? {{DATA_W{1'b0}}, rs_abs} : '0;
`ifdef MDU_EARLY_TERM_EN
                                state_reg <= (op_mul && (rt_abs == '0)) ? S_COMMIT : S_ITER;
`else
                                state_reg <= S_ITER;
`endif
                            end
                        end
                    end
                end
                S_ITER: begin
                    if (Flush) begin
                        state_reg <= S_IDLE;
                    end else begin
                        if (is_div_reg) begin
                            acc_reg <= div_next;
                        end else begin
                            acc_reg   <= mul_next;
                            mcand_reg <= {mcand_reg[2*DATA_W-2:0], 1'b0};
                            b_reg     <= {1'b0, b_reg[DATA_W-1:1]};
                        end
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_iter) begin
                            state_reg <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    state_reg <= S_IDLE;
                    if (!Flush) begin
                        done_reg <= 1'b1;
                        if (dbz_reg) begin
                            hi_reg <= acc_reg[2*DATA_W-1:DATA_W];
                            lo_reg <= '1;
                        end else if (is_div_reg) begin
                            hi_reg <= rem;
                            lo_reg <= quo;
                        end else begin
                            hi_reg <= prod[2*DATA_W-1:DATA_W];
                            lo_reg <= prod[DATA_W-1:0];
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign HI    = hi_reg;
    assign LO    = lo_reg;
    assign Busy  = (state_reg != S_IDLE);
    assign Done  = done_reg;
    assign Stall = Busy & (Read_Req | Start);

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus queues expected HI/LO, a monitor checks them on Done.
module tb_mdu_hilo;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] RS_Data;
    logic [31:0] RT_Data;
    logic        Read_Req;
    logic        Flush;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        Stall;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

`ifdef MDU_EARLY_TERM_EN
    localparam int B_MUL5  = 4;
    localparam int B_MUL0  = 1;
    localparam int B_MUL9  = 5;
`else
    localparam int B_MUL5  = 33;
    localparam int B_MUL0  = 33;
    localparam int B_MUL9  = 33;
`endif

    mdu_hilo #(.DATA_W(32), .ITER(32)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .Op(Op),
        .RS_Data(RS_Data), .RT_Data(RT_Data), .Read_Req(Read_Req), .Flush(Flush),
        .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued result.
    always @(negedge CLK) begin
        if (!RESET && Done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got Done=1 with HI=0x%08h LO=0x%08h, expected no Done", HI, LO);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_hi", HI, mon_e[63:32]);
                check("done_lo", LO, mon_e[31:0]);
                check("done_busy_low", 32'(Busy), 32'd0);
                $display("done: HI=0x%08h LO=0x%08h", HI, LO);
            end
        end
    end

    task automatic run_busy(input string name, input int exp_busy, input int inj_at,
                            input int fl_at, input int rst_at);
        int cnt = 0;
        int hold_err = 0;
        int stall_err = 0;
        bit timeout = 1'b1;
        bit injected = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (injected) begin
                Start = 1'b0;
                injected = 1'b0;
            end
            if (!Busy) begin
                timeout = 1'b0;
                break;
            end
            cnt++;
            if (HI !== model_hi || LO !== model_lo) hold_err++;
            if (Read_Req && !Stall) stall_err++;
            if (cnt == inj_at) begin
                Start = 1'b1; Op = 3'b000; RS_Data = 32'd3; RT_Data = 32'd3;
                injected = 1'b1;
                #1 check({name, "_inject_stall"}, 32'(Stall), 32'd1);
            end
            if (cnt == fl_at) Flush = 1'b1;
            if (cnt == rst_at) RESET = 1'b1;
        end
        Flush = 1'b0;
        RESET = 1'b0;
        if (timeout) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got Busy still high after 100 cycles, expected it to drop", name);
        end
        check({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
        check({name, "_hold_errs"}, 32'(hold_err), 32'd0);
        check({name, "_stall_errs"}, 32'(stall_err), 32'd0);
        if (Read_Req) check({name, "_stall_on_done"}, 32'(Stall), 32'd0);
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                         input int ebusy, input bit rd, input int inj_at);
        @(posedge CLK); #1;
        Start = 1'b1; Op = op; RS_Data = rs; RT_Data = rt; Read_Req = rd;
        exp_q.push_back({ehi, elo});
        @(posedge CLK); #1;
        Start = 1'b0;
        run_busy(name, ebusy, inj_at, 0, 0);
        model_hi = ehi;
        model_lo = elo;
        Read_Req = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; Start = 1'b0; Op = 3'b000; RS_Data = '0; RT_Data = '0;
        Read_Req = 1'b0; Flush = 1'b0;
        model_hi = '0; model_lo = '0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);

        issue("mult_neg3x5", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, B_MUL5, 1'b0, 0);
        issue("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b1, 0);
        issue("mult_by0", 3'b000, 32'hFFFF1234, 32'd0, 32'd0, 32'd0, B_MUL0, 1'b0, 0);
        issue("div_neg7by2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 0);
        issue("divu_7by2", 3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 33, 1'b0, 0);
        issue("divu_by0", 3'b011, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1, 1'b1, 0);
        issue("div_neg_by0", 3'b010, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1, 1'b0, 0);
        issue("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0, 0);
        issue("divu_inject", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 10);

        // MTHI then MTLO on consecutive cycles
        @(posedge CLK); #1;
        Start = 1'b1; Op = 3'b100; RS_Data = 32'hAAAA5555;
        @(posedge CLK); #1;
        Op = 3'b101; RS_Data = 32'h0F0F0F0F;
        check("mthi_hi", HI, 32'hAAAA5555);
        check("mthi_busy", 32'(Busy), 32'd0);
        @(posedge CLK); #1;
        Start = 1'b0;
        check("mtlo_lo", LO, 32'h0F0F0F0F);
        check("mtlo_hi_kept", HI, 32'hAAAA5555);
        check("mtlo_busy", 32'(Busy), 32'd0);
        $display("mt: HI=0x%08h LO=0x%08h", HI, LO);
        model_hi = 32'hAAAA5555;
        model_lo = 32'h0F0F0F0F;

        // Flush in the same cycle as MTHI drops it
        @(posedge CLK); #1;
        Start = 1'b1; Flush = 1'b1; Op = 3'b100; RS_Data = 32'h12345678;
        @(posedge CLK); #1;
        Start = 1'b0; Flush = 1'b0;
        check("flush_mthi_hi", HI, model_hi);
        $display("flush+mthi: HI=0x%08h", HI);

        // Reserved opcode has no effect
        @(posedge CLK); #1;
        Start = 1'b1; Op = 3'b110; RS_Data = 32'h11111111; RT_Data = 32'h22222222;
        @(posedge CLK); #1;
        Start = 1'b0;
        check("reserved_busy", 32'(Busy), 32'd0);
        check("reserved_hi", HI, model_hi);
        check("reserved_lo", LO, model_lo);
        $display("reserved op: HI=0x%08h LO=0x%08h", HI, LO);

        // Flush at busy cycle 5: no Done, HI/LO unchanged
        @(posedge CLK); #1;
        Start = 1'b1; Op = 3'b000; RS_Data = 32'd7; RT_Data = 32'd9;
        @(posedge CLK); #1;
        Start = 1'b0;
        run_busy("flush_mult", 5, 0, 5, 0);
        repeat (40) @(negedge CLK);
        check("flush_hi", HI, model_hi);
        check("flush_lo", LO, model_lo);
        check("flush_busy", 32'(Busy), 32'd0);
        $display("flush: HI=0x%08h LO=0x%08h", HI, LO);

        // Reset at busy cycle 5 clears HI/LO
        @(posedge CLK); #1;
        Start = 1'b1; Op = 3'b000; RS_Data = 32'd7; RT_Data = 32'h00000100;
        @(posedge CLK); #1;
        Start = 1'b0;
        run_busy("reset_mult", 5, 0, 0, 5);
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge CLK);
        check("midreset_hi", HI, 32'd0);
        check("midreset_lo", LO, 32'd0);
        check("midreset_busy", 32'(Busy), 32'd0);
        $display("mid-op reset: HI=0x%08h LO=0x%08h", HI, LO);

        repeat (3) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
